// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// Digit-serial adder/subtractor: a +/- b +/- carry, DIGIT bits resolved per clock.
// Latency: operands accepted at edge k, result valid after edge k + WIDTH/DIGIT.
// Backpressure: result held in DONE while i_out_ready=0; no new operands taken until it drains.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_in_valid / o_in_ready      operand handshake (i_a, i_b, i_cin, i_sub)
//   i_sub                        0: a+b+cin, 1: a-b-cin (cin acts as borrow-in)
//   o_out_valid / i_out_ready    result handshake (o_sum, o_cout, o_ovf)
//   o_cout                       raw carry out of the MSB (subtract: 1 = no borrow)
//   o_ovf                        signed overflow (carry into MSB xor carry out of MSB)
//   o_busy                       an operation is in flight or waiting to be taken
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);

  // Parameter sanity: the operand must split into a whole number of digits.
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_a;       // remaining digits of a, LSB digit next
  logic [WIDTH-1:0]   r_b;       // remaining digits of b_eff (already inverted for subtract)
  logic               r_carry;   // carry into the digit being processed
  logic [CNT_W-1:0]   r_cnt;     // index of the digit being processed

  logic [WIDTH-1:0]   r_sum;     // last completed result, only written on completion
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_a_d;
  logic [DIGIT-1:0]   w_b_d;
  logic [DIGIT:0]     w_dsum;
  logic               w_dig_cout;
  logic               w_dig_cmsb;
  logic [WIDTH-1:0]   w_res;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_in_valid)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last)      w_state_nxt = S_DONE;
      S_DONE: if (i_out_ready) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // in_ready is gated by reset so an operand offered during reset is never
    // seen as accepted upstream.
    o_in_ready  = (r_state == S_IDLE) && !i_rst;
    o_out_valid = (r_state == S_DONE);
    o_busy      = (r_state == S_RUN) || (r_state == S_DONE);
  end

  assign w_accept = o_in_ready && i_in_valid;
  assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

  // ---------------------------------------------------------------------------
  // Digit adder: one DIGIT-wide ripple slice per cycle
  // ---------------------------------------------------------------------------
  assign w_a_d      = r_a[DIGIT-1:0];
  assign w_b_d      = r_b[DIGIT-1:0];
  assign w_dsum     = {1'b0, w_a_d} + {1'b0, w_b_d} + {{DIGIT{1'b0}}, r_carry};
  assign w_dig_cout = w_dsum[DIGIT];
  // Carry that entered the top bit of this slice: sum bit = a ^ b ^ carry_in,
  // so carry_in = sum ^ a ^ b. On the last slice this is the carry into the MSB.
  assign w_dig_cmsb = w_dsum[DIGIT-1] ^ w_a_d[DIGIT-1] ^ w_b_d[DIGIT-1];

  // ---------------------------------------------------------------------------
  // Result assembly. Digits enter at the top and move down, so after the last
  // slice the first digit sits in the LSBs. Only WIDTH-DIGIT bits of history
  // are needed because the newest digit comes straight from the adder.
  // ---------------------------------------------------------------------------
  if (DIGIT == WIDTH) begin : g_single
    assign w_res = w_dsum[DIGIT-1:0];
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_hist;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_hist <= '0;
      end else if (r_state == S_RUN) begin
        r_hist <= w_res[WIDTH-1:DIGIT];
      end
    end

    assign w_res = {w_dsum[DIGIT-1:0], r_hist};
  end

  // ---------------------------------------------------------------------------
  // Operand / carry / counter / result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        // a - b - cin == a + ~b + ~cin, so subtract just inverts b and the carry.
        r_a     <= i_a;
        r_b     <= i_sub ? ~i_b : i_b;
        r_carry <= i_cin ^ i_sub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dig_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          // Published only here so partial results never reach o_sum.
          r_sum  <= w_res;
          r_cout <= w_dig_cout;
          r_ovf  <= w_dig_cmsb ^ w_dig_cout;
        end
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// Bench for serial_adder: three instances (DIGIT = 2, 1, 8, WIDTH = 8) share
// the same stimulus; results are checked against an integer-arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_cin;
  logic       op_sub;
  logic       out_ready;

  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] cout;
  logic [2:0] ovf;
  logic [2:0] busy;
  logic [7:0] sum_d [3];

  int n_checks = 0;
  int n_errors = 0;

  int lat_exp [3] = '{4, 8, 1};
  int dig     [3] = '{2, 1, 8};

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready[0]),
    .i_a(op_a), .i_b(op_b), .i_cin(op_cin), .i_sub(op_sub),
    .o_out_valid(out_valid[0]), .i_out_ready(out_ready),
    .o_sum(sum_d[0]), .o_cout(cout[0]), .o_ovf(ovf[0]), .o_busy(busy[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready[1]),
    .i_a(op_a), .i_b(op_b), .i_cin(op_cin), .i_sub(op_sub),
    .o_out_valid(out_valid[1]), .i_out_ready(out_ready),
    .o_sum(sum_d[1]), .o_cout(cout[1]), .o_ovf(ovf[1]), .o_busy(busy[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready[2]),
    .i_a(op_a), .i_b(op_b), .i_cin(op_cin), .i_sub(op_sub),
    .o_out_valid(out_valid[2]), .i_out_ready(out_ready),
    .o_sum(sum_d[2]), .o_cout(cout[2]), .o_ovf(ovf[2]), .o_busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    int ua, ub, sa, sb, ci, ru, rs;
    logic [7:0] rsum;
    logic       rc;
    logic       rv;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = c ? 1 : 0;
    if (!s) begin
      ru = ua + ub + ci;
      rs = sa + sb + ci;
    end else begin
      ru = 256 + ua - ub - ci;   // bit 8 set means no borrow
      rs = sa - sb - ci;
    end
    rsum = ru[7:0];
    rc   = (ru >= 256);
    rv   = (rs > 127) || (rs < -128);
    return {rv, rc, rsum};
  endfunction

  function automatic logic [31:0] res_of(input int i);
    return {22'd0, ovf[i], cout[i], sum_d[i]};
  endfunction

  task automatic wait_idle();
    int w;
    w = 0;
    while (in_ready !== 3'b111 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd7);
  endtask

  // One operation on all instances with out_ready held high; checks latency
  // and result of each instance when its out_valid first appears.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input logic [9:0] exp);
    int m;
    logic [2:0] seen;
    wait_idle();
    out_ready = 1'b1;
    op_a = a; op_b = b; op_cin = c; op_sub = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // latched copies must be used, so scramble the live operands
    op_a = 8'($urandom); op_b = 8'($urandom);
    op_cin = 1'($urandom); op_sub = 1'($urandom);
    check("busy_after_accept", 32'(busy), 32'd7);
    check("no_early_valid", 32'(out_valid), 32'd0);
    seen = 3'b000;
    m = 0;
    while (seen != 3'b111 && m < 20) begin
      @(negedge clk);
      m++;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid[i]) begin
          seen[i] = 1'b1;
          check($sformatf("latency_d%0d", dig[i]), 32'(m), 32'(lat_exp[i]));
          check($sformatf("result_d%0d a=%0h b=%0h c=%0b s=%0b", dig[i], a, b, c, s),
                res_of(i), {22'd0, exp});
        end
      end
    end
    if (seen != 3'b111) check("timeout_out_valid", 32'(seen), 32'd7);
  endtask

  logic [7:0] da [8] = '{8'h3C, 8'h7F, 8'hFF, 8'hFF, 8'h05, 8'h80, 8'h10, 8'hAA};
  logic [7:0] db [8] = '{8'h15, 8'h01, 8'h01, 8'h00, 8'h07, 8'h01, 8'h0F, 8'h55};
  logic       dc [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
  logic       ds [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
  logic [9:0] de [8] = '{10'h051, 10'h280, 10'h100, 10'h100,
                         10'h0FE, 10'h37F, 10'h100, 10'h0FF};

  initial begin
    int w;
    logic [7:0] ra, rb;
    logic       rc, rs;

    // ---- reset, with an operand offered that must be ignored
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    op_a = 8'h3C; op_b = 8'h15; op_cin = 1'b0; op_sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) check($sformatf("rst_result_d%0d", dig[i]), res_of(i), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd7);
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // ---- directed vectors
    for (int t = 0; t < 8; t++) run_op(da[t], db[t], dc[t], ds[t], de[t]);

    // ---- backpressure: hold DONE 10 cycles while inputs toggle
    wait_idle();
    out_ready = 1'b0;
    op_a = 8'h7F; op_b = 8'h01; op_cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (out_valid !== 3'b111 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("hold_reach_done", 32'(out_valid), 32'd7);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'($urandom);
      op_a = 8'($urandom); op_b = 8'($urandom);
      op_cin = 1'($urandom); op_sub = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++)
        check($sformatf("hold_result_d%0d", dig[i]), res_of(i), 32'h280);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd7);
    for (int i = 0; i < 3; i++)
      check($sformatf("held_after_done_d%0d", dig[i]), res_of(i), 32'h280);

    // ---- reset two cycles after accept
    wait_idle();
    op_a = 8'h3C; op_b = 8'h15; op_cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);             // accepted at the edge just passed
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;                 // sampled at accept edge + 2
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("mid_rst_result_d%0d", dig[i]), res_of(i), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_rst_no_pulse", 32'(out_valid), 32'd0);
    end
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 10'h002);

    // ---- random operations against the model
    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
